// File: rtl/eff_flanger_ctrl.sv
// eff_flanger_ctrl: per-sample control scheduler for the flanger effect.
// On each vld_i strobe it steps a triangle LFO that sets the delay tap, and
// it runs a wet-mix fade-in/fade-out sequence whenever en changes level.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   en        effect enable request (level, sampled only on vld_i)
//   vld_i     one-cycle sample strobe; all state advances only on this
//   rate      LFO step, unsigned 0.16 fixed point (samples per sample)
//   depth     sweep amplitude in whole samples
//   delay_o   delay tap = MIN_DELAY + int(pos), saturating
//   mix_o     wet-mix gain
//   upd_o     one-cycle pulse the cycle after each vld_i
//   active_o  high whenever the FSM is not IDLE
//
// state    | meaning
// IDLE     | effect off, mix 0, LFO parked at 0 going up
// FADE_IN  | mix ramping up by FADE_STEP per sample
// RUN      | mix held at MIX_MAX
// FADE_OUT | mix ramping down by FADE_STEP per sample

module eff_flanger_ctrl #(
  parameter int DELAY_WIDTH = 10,
  parameter int MIX_WIDTH   = 8,
  parameter int MIN_DELAY   = 16,
  parameter int FADE_STEP   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   vld_i,
  input  logic [15:0]            rate,
  input  logic [DELAY_WIDTH-1:0] depth,
  output logic [DELAY_WIDTH-1:0] delay_o,
  output logic [MIX_WIDTH-1:0]   mix_o,
  output logic                   upd_o,
  output logic                   active_o
);

  localparam int PW = DELAY_WIDTH + 16;
  localparam logic [MIX_WIDTH-1:0]   MIX_MAX = '1;
  localparam logic [DELAY_WIDTH:0]   DLY_MAX = {1'b0, {DELAY_WIDTH{1'b1}}};
  localparam logic [DELAY_WIDTH-1:0] MIN_D   = DELAY_WIDTH'(MIN_DELAY);

  typedef enum logic [1:0] {IDLE, FADE_IN, RUN, FADE_OUT} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          pos_q, pos_d;
  logic                   dir_q, dir_d;      // 1 = sweeping down
  logic [MIX_WIDTH-1:0]   mix_q, mix_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic                   upd_q, active_q;

  // Saturating mix step helpers; 32-bit math so FADE_STEP may exceed MIX_MAX.
  logic [31:0]          mix_up32;
  logic [MIX_WIDTH-1:0] mix_inc, mix_dec;

  assign mix_up32 = 32'(mix_q) + 32'(FADE_STEP);
  assign mix_inc  = (mix_up32 >= 32'(MIX_MAX)) ? MIX_MAX : mix_up32[MIX_WIDTH-1:0];
  // The subtraction branch is only taken when mix_q > FADE_STEP, so the
  // truncated step is exact there.
  assign mix_dec  = (32'(mix_q) <= 32'(FADE_STEP)) ? '0
                                                   : mix_q - MIX_WIDTH'(FADE_STEP);

  // Next mix/state for one sample. Every state follows the same rule: en
  // steps the mix up, !en steps it down, and the new mix decides where we land.
  always_comb begin
    state_d = state_q;
    mix_d   = mix_q;
    case (state_q)
      IDLE:     mix_d = en ? mix_inc : '0;
      FADE_IN:  mix_d = en ? mix_inc : mix_dec;
      RUN:      mix_d = en ? MIX_MAX : mix_dec;
      FADE_OUT: mix_d = en ? mix_inc : mix_dec;
      default:  mix_d = '0;
    endcase
    if (mix_d == MIX_MAX)  state_d = RUN;
    else if (mix_d == '0)  state_d = IDLE;
    else if (en)           state_d = FADE_IN;
    else                   state_d = FADE_OUT;
  end

  // Triangle LFO, DELAY_WIDTH.16 fixed point. Turnarounds land exactly on
  // the limit. Keyed off the next state so the entry sample already moves
  // and the exit sample parks at 0.
  logic [PW:0]          p_up;
  logic [DELAY_WIDTH:0] p_int;
  logic [PW-1:0]        depth_fx, rate_fx;

  assign p_up     = (PW+1)'(pos_q) + (PW+1)'(rate);
  assign p_int    = p_up[PW:16];
  assign depth_fx = {depth, 16'h0000};
  assign rate_fx  = PW'(rate);

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (state_d == IDLE) begin
      pos_d = '0;
      dir_d = 1'b0;
    end else if (pos_q[PW-1:16] > depth) begin
      // depth was lowered under the current position
      pos_d = depth_fx;
      dir_d = 1'b1;
    end else if (!dir_q) begin
      if (p_int >= {1'b0, depth}) begin
        pos_d = depth_fx;
        dir_d = 1'b1;
      end else begin
        pos_d = p_up[PW-1:0];
      end
    end else begin
      if (pos_q <= rate_fx) begin
        pos_d = '0;
        dir_d = 1'b0;
      end else begin
        pos_d = pos_q - rate_fx;
      end
    end
  end

  logic [DELAY_WIDTH:0] dly_sum;
  assign dly_sum = (DELAY_WIDTH+1)'(MIN_DELAY) + {1'b0, pos_d[PW-1:16]};
  assign delay_d = (dly_sum > DLY_MAX) ? DLY_MAX[DELAY_WIDTH-1:0]
                                       : dly_sum[DELAY_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      mix_q    <= '0;
      delay_q  <= MIN_D;
      upd_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      upd_q <= vld_i;
      if (vld_i) begin
        state_q  <= state_d;
        pos_q    <= pos_d;
        dir_q    <= dir_d;
        mix_q    <= mix_d;
        delay_q  <= delay_d;
        active_q <= (state_d != IDLE);
      end
    end
  end

  assign delay_o  = delay_q;
  assign mix_o    = mix_q;
  assign upd_o    = upd_q;
  assign active_o = active_q;

endmodule

// File: tb/tb_eff_flanger_ctrl.sv
// Directed bench for eff_flanger_ctrl. A second instance with FADE_STEP
// larger than MIX_MAX shares the stimulus to cover the one-sample fade.
module tb_eff_flanger_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, vld_i;
  logic [15:0] rate;
  logic [9:0]  depth;
  logic [9:0]  delay_o, delay2_o;
  logic [7:0]  mix_o, mix2_o;
  logic        upd_o, upd2_o, active_o, active2_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  eff_flanger_ctrl #(.DELAY_WIDTH(10), .MIX_WIDTH(8), .MIN_DELAY(16), .FADE_STEP(8)) dut (
    .clk(clk), .rst(rst), .en(en), .vld_i(vld_i), .rate(rate), .depth(depth),
    .delay_o(delay_o), .mix_o(mix_o), .upd_o(upd_o), .active_o(active_o)
  );

  eff_flanger_ctrl #(.DELAY_WIDTH(10), .MIX_WIDTH(8), .MIN_DELAY(16), .FADE_STEP(512)) dut2 (
    .clk(clk), .rst(rst), .en(en), .vld_i(vld_i), .rate(rate), .depth(depth),
    .delay_o(delay2_o), .mix_o(mix2_o), .upd_o(upd2_o), .active_o(active2_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe; leaves the bench one negedge after the update cycle.
  task automatic strobe();
    @(negedge clk) vld_i = 1'b1;
    @(negedge clk) vld_i = 1'b0;
    check("upd_pulse", int'(upd_o), 1);
    @(negedge clk);
    check("upd_clear", int'(upd_o), 0);
  endtask

  // rate=0.5, depth=4, starting at pos 0 going up: period of 16 strobes,
  // pos = h/2 with h the triangle position in half-samples.
  function automatic int tri_dly(input int k);
    int t, h;
    t = k % 16;
    h = (t <= 8) ? t : 16 - t;
    return 16 + h / 2;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; vld_i = 1'b0; rate = '0; depth = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_delay",  int'(delay_o),  16);
    check("rst_mix",    int'(mix_o),    0);
    check("rst_upd",    int'(upd_o),    0);
    check("rst_active", int'(active_o), 0);

    // Fade-in with LFO sweep
    en = 1'b1; rate = 16'h8000; depth = 10'd4;
    for (int k = 1; k <= 32; k++) begin
      strobe();
      check("fi_mix",    int'(mix_o), (k < 32) ? 8 * k : 255);
      check("fi_delay",  int'(delay_o), tri_dly(k));
      check("fi_active", int'(active_o), 1);
      if (k == 1) begin
        check("big_step_mix",    int'(mix2_o), 255);
        check("big_step_active", int'(active2_o), 1);
      end
    end

    // Fade-out from RUN
    en = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      strobe();
      check("fo_mix",    int'(mix_o), (j < 32) ? 247 - 8 * (j - 1) : 0);
      check("fo_delay",  int'(delay_o), (j < 32) ? tri_dly(32 + j) : 16);
      check("fo_active", int'(active_o), (j < 32) ? 1 : 0);
      if (j == 1) begin
        check("big_step_off_mix",    int'(mix2_o), 0);
        check("big_step_off_active", int'(active2_o), 0);
      end
    end
    strobe();
    check("idle_mix",    int'(mix_o), 0);
    check("idle_delay",  int'(delay_o), 16);
    check("idle_active", int'(active_o), 0);

    // Reversal in the middle of a fade-in
    en = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      strobe();
      check("fi2_mix",   int'(mix_o), 8 * j);
      check("fi2_delay", int'(delay_o), tri_dly(j));
    end
    en = 1'b0;
    strobe();
    check("rev_down_mix",    int'(mix_o), 56);
    check("rev_down_active", int'(active_o), 1);
    en = 1'b1;
    strobe();
    check("rev_up_mix", int'(mix_o), 64);
    // en glitch between strobes is ignored
    @(negedge clk) en = 1'b0;
    @(negedge clk) en = 1'b1;
    strobe();
    check("glitch_mix", int'(mix_o), 72);
    for (int j = 1; j <= 23; j++) strobe();
    check("fi2_run_mix", int'(mix_o), 255);

    // Depth lowered under the current position, then rate frozen
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    en = 1'b1; depth = 10'd20; rate = 16'h0000;
    strobe(); strobe();
    rate = 16'h8000;
    for (int j = 1; j <= 30; j++) strobe();
    check("d20_mix",   int'(mix_o), 255);
    check("d20_delay", int'(delay_o), 31);
    depth = 10'd5;
    strobe();
    check("clamp_delay", int'(delay_o), 21);
    rate = 16'h0000;
    for (int j = 1; j <= 50; j++) begin
      strobe();
      check("frozen_delay", int'(delay_o), 21);
    end
    rate = 16'h8000;
    strobe();
    check("dir_down_delay", int'(delay_o), 20);

    // Reset coincident with a strobe
    @(negedge clk) begin rst = 1'b1; vld_i = 1'b1; end
    @(negedge clk) begin rst = 1'b0; vld_i = 1'b0; end
    check("rstv_mix",    int'(mix_o), 0);
    check("rstv_delay",  int'(delay_o), 16);
    check("rstv_upd",    int'(upd_o), 0);
    check("rstv_active", int'(active_o), 0);
    en = 1'b1; rate = 16'h8000; depth = 10'd4;
    strobe();
    check("post_rst_mix",    int'(mix_o), 8);
    check("post_rst_delay",  int'(delay_o), 16);
    check("post_rst_active", int'(active_o), 1);

    // No strobes for 1000 clocks while inputs wander
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      en = 1'($urandom);
      rate = 16'($urandom);
      depth = 10'($urandom);
      if (i % 100 == 0) begin
        check("hold_mix",    int'(mix_o), 8);
        check("hold_delay",  int'(delay_o), 16);
        check("hold_upd",    int'(upd_o), 0);
        check("hold_active", int'(active_o), 1);
      end
    end
    en = 1'b1; rate = 16'h8000; depth = 10'd4;
    strobe();
    check("resume_mix",   int'(mix_o), 16);
    check("resume_delay", int'(delay_o), 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
